// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module   : free_list_pkg
// Brief    : Shared rename-side sizes and index types for the PRF free list.
// Revision : 1.0 - initial release
// ============================================================================
package free_list_pkg;

    localparam int PRF_INT_SIZE = 64;
    localparam int ARF_INT_SIZE = 32;
    localparam int RAT_CP_SIZE  = 4;
    localparam int FL_DEPTH     = PRF_INT_SIZE - ARF_INT_SIZE;

    typedef logic [$clog2(RAT_CP_SIZE)-1:0]  cp_index_t;
    typedef logic [$clog2(FL_DEPTH):0]       fl_ptr_t;
    typedef logic [$clog2(PRF_INT_SIZE)-1:0] prf_index_t;

endpackage
`default_nettype wire

// File: rtl/free_list_prefix_popcount.sv
`default_nettype none
// ============================================================================
// Module   : free_list_prefix_popcount
// Brief    : Exclusive prefix population counts of a request vector.
// Revision : 1.0 - initial release
// ============================================================================
module free_list_prefix_popcount #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]       i_bits,
    output logic [WIDTH*CNT_W-1:0] o_prefix,
    output logic [CNT_W-1:0]       o_total
);

    logic [CNT_W-1:0] w_acc;

    // o_prefix slot i holds the number of set bits strictly below i.
    always_comb begin
        w_acc    = '0;
        o_prefix = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_prefix[i*CNT_W +: CNT_W] = w_acc;
            w_acc = w_acc + CNT_W'(i_bits[i]);
        end
        o_total = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Brief    : Circular free list of PRF indices with checkpointed head pointer.
// Revision : 1.0 - initial release
// ============================================================================
module free_list
    import free_list_pkg::*;
#(
    parameter int PRF_SIZE     = PRF_INT_SIZE,
    parameter int ARF_SIZE     = ARF_INT_SIZE,
    parameter int RENAME_WIDTH = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int CP_SIZE      = RAT_CP_SIZE,
    parameter int DEPTH        = PRF_SIZE - ARF_SIZE
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [RENAME_WIDTH-1:0]                  alloc_req,
    output logic [RENAME_WIDTH*$clog2(PRF_SIZE)-1:0] alloc_prf,
    output logic                                     alloc_ok,
    input  logic [COMMIT_WIDTH-1:0]                  free_req,
    input  logic [COMMIT_WIDTH*$clog2(PRF_SIZE)-1:0] free_prf,
    input  logic                                     check,
    input  logic [$clog2(CP_SIZE)-1:0]               check_idx,
    input  logic [RENAME_WIDTH-1:0]                  check_flag,
    input  logic                                     recover,
    input  logic [$clog2(CP_SIZE)-1:0]               recover_idx,
    output logic [$clog2(DEPTH):0]                   free_count,
    output logic                                     overflow
);

    localparam int c_prf_w  = $clog2(PRF_SIZE);
    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_ptr_w  = c_idx_w + 1;
    localparam int c_rcnt_w = $clog2(RENAME_WIDTH + 1);
    localparam int c_ccnt_w = $clog2(COMMIT_WIDTH + 1);
    localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(DEPTH);

    logic [c_prf_w-1:0]  r_fifo [DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_ptr_w-1:0]  r_free_count;
    logic                r_overflow;
    logic [c_ptr_w-1:0]  r_cp_head [CP_SIZE];

    logic [RENAME_WIDTH*c_rcnt_w-1:0] w_alloc_pre;
    logic [c_rcnt_w-1:0]              w_alloc_n;
    logic [COMMIT_WIDTH*c_ccnt_w-1:0] w_free_pre;
    logic [c_ccnt_w-1:0]              w_free_n;

    logic                    w_alloc_ok;
    logic [c_ptr_w-1:0]      w_rd_ptr [RENAME_WIDTH];
    logic [c_ptr_w-1:0]      w_head_next;
    logic [c_ptr_w-1:0]      w_tail_next;
    logic [c_ptr_w-1:0]      w_used_next;
    logic [c_ptr_w-1:0]      w_room;
    logic [c_ptr_w-1:0]      w_free_acc;
    logic                    w_ovf_set;
    logic [COMMIT_WIDTH-1:0] w_wr_en;
    logic [c_ptr_w-1:0]      w_wr_ptr [COMMIT_WIDTH];
    logic                    w_cp_we;
    logic [c_ptr_w-1:0]      w_cp_val;

    free_list_prefix_popcount #(
        .WIDTH    (RENAME_WIDTH)
    ) u_alloc_popcount (
        .i_bits   (alloc_req),
        .o_prefix (w_alloc_pre),
        .o_total  (w_alloc_n)
    );

    free_list_prefix_popcount #(
        .WIDTH    (COMMIT_WIDTH)
    ) u_free_popcount (
        .i_bits   (free_req),
        .o_prefix (w_free_pre),
        .o_total  (w_free_n)
    );

    assign w_alloc_ok = (r_free_count >= c_ptr_w'(w_alloc_n)) && !recover;

    always_comb begin
        alloc_prf = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            w_rd_ptr[i] = r_head + c_ptr_w'(w_alloc_pre[i*c_rcnt_w +: c_rcnt_w]);
            if (alloc_req[i]) begin
                alloc_prf[i*c_prf_w +: c_prf_w] = r_fifo[w_rd_ptr[i][c_idx_w-1:0]];
            end
        end
    end

    always_comb begin
        w_head_next = r_head;
        if (recover) begin
            w_head_next = r_cp_head[recover_idx];
        end else if (w_alloc_ok) begin
            w_head_next = r_head + c_ptr_w'(w_alloc_n);
        end
    end

    // Room is measured against the post-update head, so same-cycle grants
    // make space for releases while a recover can take space away.
    always_comb begin
        w_used_next = r_tail - w_head_next;
        w_room      = (w_used_next > c_depth) ? '0 : (c_depth - w_used_next);
        w_ovf_set   = c_ptr_w'(w_free_n) > w_room;
        w_free_acc  = w_ovf_set ? w_room : c_ptr_w'(w_free_n);
        w_tail_next = r_tail + w_free_acc;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            w_wr_ptr[j] = r_tail + c_ptr_w'(w_free_pre[j*c_ccnt_w +: c_ccnt_w]);
            w_wr_en[j]  = free_req[j]
                        && (c_ptr_w'(w_free_pre[j*c_ccnt_w +: c_ccnt_w]) < w_room);
        end
    end

    // The checkpointed head lands just past the branch slot's own grant.
    always_comb begin
        w_cp_we  = 1'b0;
        w_cp_val = r_head;
        if (check && w_alloc_ok) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (check_flag[i]) begin
                    w_cp_we  = 1'b1;
                    w_cp_val = r_head
                             + c_ptr_w'(w_alloc_pre[i*c_rcnt_w +: c_rcnt_w])
                             + c_ptr_w'(alloc_req[i]);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_fifo[k] <= c_prf_w'(ARF_SIZE + k);
            end
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (w_wr_en[j]) begin
                    r_fifo[w_wr_ptr[j][c_idx_w-1:0]] <= free_prf[j*c_prf_w +: c_prf_w];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head       <= '0;
            r_tail       <= c_depth;
            r_free_count <= c_depth;
            r_overflow   <= 1'b0;
            for (int c = 0; c < CP_SIZE; c++) begin
                r_cp_head[c] <= '0;
            end
        end else begin
            r_head       <= w_head_next;
            r_tail       <= w_tail_next;
            r_free_count <= w_tail_next - w_head_next;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_cp_we) begin
                r_cp_head[check_idx] <= w_cp_val;
            end
        end
    end

    assign alloc_ok   = w_alloc_ok;
    assign free_count = r_free_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Brief    : Directed and randomized self-checking bench for free_list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

    localparam int PW = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  alloc_req;
    logic [23:0] alloc_prf;
    logic        alloc_ok;
    logic [3:0]  free_req;
    logic [23:0] free_prf;
    logic        check;
    logic [1:0]  check_idx;
    logic [3:0]  check_flag;
    logic        recover;
    logic [1:0]  recover_idx;
    logic [5:0]  free_count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the free list as an unbounded sequence of positions.
    int m_store [int];
    int m_head;
    int m_tail;
    int m_cp [4];
    bit m_ovf;
    bit e_ok;
    int e_prf [4];

    typedef struct {
        int prf;
        int pos;
    } use_t;
    use_t pool [$];

    free_list dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_prf   (alloc_prf),
        .alloc_ok    (alloc_ok),
        .free_req    (free_req),
        .free_prf    (free_prf),
        .check       (check),
        .check_idx   (check_idx),
        .check_flag  (check_flag),
        .recover     (recover),
        .recover_idx (recover_idx),
        .free_count  (free_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [5:0] prf(input int slot);
        return alloc_prf[slot*PW +: PW];
    endfunction

    task automatic set_in(input logic [3:0] areq, input logic [3:0] freq,
                          input logic [23:0] fprf, input logic chk,
                          input logic [1:0] cidx, input logic [3:0] cflag,
                          input logic rec, input logic [1:0] ridx);
        alloc_req   = areq;
        free_req    = freq;
        free_prf    = fprf;
        check       = chk;
        check_idx   = cidx;
        check_flag  = cflag;
        recover     = rec;
        recover_idx = ridx;
    endtask

    task automatic idle();
        set_in(4'b0, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic model_reset();
        m_store.delete();
        for (int k = 0; k < 32; k++) m_store[k] = 32 + k;
        m_head = 0;
        m_tail = 32;
        for (int c = 0; c < 4; c++) m_cp[c] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_eval();
        int n;
        int r;
        n = 0;
        for (int i = 0; i < 4; i++) if (alloc_req[i]) n++;
        e_ok = ((m_tail - m_head) >= n) && !recover;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            e_prf[i] = 0;
            if (alloc_req[i]) begin
                if (m_store.exists(m_head + r)) e_prf[i] = m_store[m_head + r];
                r++;
            end
        end
    endtask

    task automatic model_commit();
        int n;
        int hn;
        int room;
        int acc;
        int r;
        n = 0;
        for (int i = 0; i < 4; i++) if (alloc_req[i]) n++;
        if (recover)   hn = m_cp[recover_idx];
        else if (e_ok) hn = m_head + n;
        else           hn = m_head;
        if (check && e_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (check_flag[i]) begin
                    r = 0;
                    for (int q = 0; q <= i; q++) if (alloc_req[q]) r++;
                    m_cp[check_idx] = m_head + r;
                end
            end
        end
        room = 32 - (m_tail - hn);
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            if (free_req[j]) begin
                if (acc < room) begin
                    m_store[m_tail + acc] = int'(free_prf[j*PW +: PW]);
                    acc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_tail = m_tail + acc;
        m_head = hn;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        #12;
        n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL reset_count: got %0d want 32", free_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL reset_ok_idle: got %0b want 1", alloc_ok); end
        n_cmp++; if (alloc_prf !== 24'd0) begin n_bad++; $display("FAIL reset_prf_idle: got %h want 0", alloc_prf); end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_alloc_all4();
        do_reset();
        set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL all4_ok: got %0b want 1", alloc_ok); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (prf(i) !== 6'(32 + i)) begin n_bad++; $display("FAIL all4_prf%0d: got %0d want %0d", i, prf(i), 32 + i); end
        end
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd28) begin n_bad++; $display("FAIL all4_count: got %0d want 28", free_count); end
    endtask

    task automatic test_alloc_sparse();
        do_reset();
        set_in(4'b1010, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (prf(1) !== 6'd32) begin n_bad++; $display("FAIL sparse_prf1: got %0d want 32", prf(1)); end
        n_cmp++; if (prf(3) !== 6'd33) begin n_bad++; $display("FAIL sparse_prf3: got %0d want 33", prf(3)); end
        n_cmp++; if (prf(0) !== 6'd0) begin n_bad++; $display("FAIL sparse_prf0: got %0d want 0", prf(0)); end
        n_cmp++; if (prf(2) !== 6'd0) begin n_bad++; $display("FAIL sparse_prf2: got %0d want 0", prf(2)); end
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd30) begin n_bad++; $display("FAIL sparse_count: got %0d want 30", free_count); end
    endtask

    task automatic test_insufficient();
        do_reset();
        set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        repeat (7) tick();
        set_in(4'b0011, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd2) begin n_bad++; $display("FAIL drain_count: got %0d want 2", free_count); end
        set_in(4'b0111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL short_ok: got %0b want 0", alloc_ok); end
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd2) begin n_bad++; $display("FAIL short_count: got %0d want 2", free_count); end
        set_in(4'b0011, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL last2_ok: got %0b want 1", alloc_ok); end
        n_cmp++; if (prf(0) !== 6'd62) begin n_bad++; $display("FAIL last2_prf0: got %0d want 62", prf(0)); end
        n_cmp++; if (prf(1) !== 6'd63) begin n_bad++; $display("FAIL last2_prf1: got %0d want 63", prf(1)); end
        tick();
        idle();
        #1;
        n_cmp++; if (free_count !== 6'd0) begin n_bad++; $display("FAIL empty_count: got %0d want 0", free_count); end
        n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL empty_ok_idle: got %0b want 1", alloc_ok); end
        set_in(4'b1000, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL empty_ok_req: got %0b want 0", alloc_ok); end
        n_cmp++; if (prf(0) !== 6'd0) begin n_bad++; $display("FAIL empty_prf0: got %0d want 0", prf(0)); end
        tick();
        idle();
    endtask

    task automatic test_checkpoint_recover();
        do_reset();
        set_in(4'b1111, 4'b0, 24'd0, 1'b1, 2'd2, 4'b0010, 1'b0, 2'd0);
        #1;
        n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL cp_ok: got %0b want 1", alloc_ok); end
        tick();
        set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (prf(0) !== 6'd36) begin n_bad++; $display("FAIL cp_more_prf0: got %0d want 36", prf(0)); end
        repeat (2) tick();
        set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b1, 2'd2);
        #1;
        n_cmp++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL rec_ok: got %0b want 0", alloc_ok); end
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd30) begin n_bad++; $display("FAIL rec_count: got %0d want 30", free_count); end
        set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (prf(i) !== 6'(34 + i)) begin n_bad++; $display("FAIL rec_prf%0d: got %0d want %0d", i, prf(i), 34 + i); end
        end
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd26) begin n_bad++; $display("FAIL rec_after_count: got %0d want 26", free_count); end
    endtask

    task automatic test_recover_with_free();
        do_reset();
        set_in(4'b1111, 4'b0, 24'd0, 1'b1, 2'd2, 4'b0010, 1'b0, 2'd0);
        tick();
        set_in(4'b0000, 4'b0001, 24'd5, 1'b0, 2'd0, 4'b0, 1'b1, 2'd2);
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd31) begin n_bad++; $display("FAIL recfree_count: got %0d want 31", free_count); end
        set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        repeat (7) tick();
        set_in(4'b0011, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (prf(1) !== 6'd63) begin n_bad++; $display("FAIL recfree_prev: got %0d want 63", prf(1)); end
        tick();
        set_in(4'b0001, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        #1;
        n_cmp++; if (prf(0) !== 6'd5) begin n_bad++; $display("FAIL recfree_prf: got %0d want 5", prf(0)); end
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd0) begin n_bad++; $display("FAIL recfree_final: got %0d want 0", free_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        set_in(4'b0011, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        tick();
        idle();
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pre: got %0b want 0", overflow); end
        set_in(4'b0, 4'b1111, {6'd12, 6'd11, 6'd33, 6'd32}, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
        tick();
        idle();
        n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL ovf_count: got %0d want 32", free_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b want 1", overflow); end
        for (int c = 0; c < 8; c++) begin
            set_in(4'b1111, 4'b0, 24'd0, 1'b0, 2'd0, 4'b0, 1'b0, 2'd0);
            #1;
            if (c == 7) begin
                n_cmp++; if (prf(2) !== 6'd32) begin n_bad++; $display("FAIL ovf_keep0: got %0d want 32", prf(2)); end
                n_cmp++; if (prf(3) !== 6'd33) begin n_bad++; $display("FAIL ovf_keep1: got %0d want 33", prf(3)); end
            end
            tick();
        end
        n_cmp++; if (free_count !== 6'd0) begin n_bad++; $display("FAIL ovf_drain: got %0d want 0", free_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL async_count: got %0d want 32", free_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL async_ovf: got %0b want 0", overflow); end
        #2;
        reset = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_random();
        bit          live;
        int          live_cp;
        int          live_slot;
        int          old_head;
        int          r;
        int          elig;
        int          allow;
        int          k;
        int          pick;
        int          st;
        logic [3:0]  areq;
        logic [3:0]  freq;
        logic [3:0]  flag;
        logic [23:0] fprf;
        logic        chk;
        logic        rec;
        logic [1:0]  cidx;
        do_reset();
        model_reset();
        pool.delete();
        for (int p = 0; p < 32; p++) pool.push_back('{p, -1});
        live      = 1'b0;
        live_cp   = 0;
        live_slot = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            areq = 4'($urandom_range(0, 15));
            chk  = 1'b0;
            rec  = 1'b0;
            flag = 4'b0;
            cidx = 2'($urandom_range(0, 3));
            if (live && $urandom_range(0, 9) == 0) begin
                rec = 1'b1;
            end else if (live && $urandom_range(0, 9) == 0) begin
                live = 1'b0;
            end else if (!live && areq != 4'b0 && $urandom_range(0, 4) == 0) begin
                chk = 1'b1;
                st  = int'($urandom_range(0, 3));
                for (int t = 0; t < 4; t++) begin
                    if (flag == 4'b0 && areq[(st + t) % 4]) flag[(st + t) % 4] = 1'b1;
                end
            end
            elig = 0;
            foreach (pool[q]) if (!live || pool[q].pos < live_cp) elig++;
            allow = elig - 32;
            if (allow > 4) allow = 4;
            if (allow < 0) allow = 0;
            k    = int'($urandom_range(0, allow));
            freq = 4'b0;
            fprf = 24'($urandom());
            for (int s = 0; s < 4; s++) begin
                if (k > 0 && ($urandom_range(0, 1) == 1 || (4 - s) <= k)) begin
                    pick = int'($urandom_range(0, pool.size() - 1));
                    while (live && pool[pick].pos >= live_cp) pick = (pick + 1) % pool.size();
                    freq[s] = 1'b1;
                    fprf[s*PW +: PW] = 6'(pool[pick].prf);
                    pool.delete(pick);
                    k--;
                end
            end
            set_in(areq, freq, fprf, chk, cidx, flag, rec, 2'(live_slot));
            model_eval();
            #1;
            n_cmp++;
            if (alloc_ok !== e_ok) begin n_bad++; $display("FAIL rnd_ok c%0d: got %0b want %0b", cyc, alloc_ok, e_ok); end
            for (int i = 0; i < 4; i++) begin
                if (!areq[i] || e_ok) begin
                    n_cmp++;
                    if (prf(i) !== 6'(e_prf[i])) begin n_bad++; $display("FAIL rnd_prf%0d c%0d: got %0d want %0d", i, cyc, prf(i), e_prf[i]); end
                end
            end
            old_head = m_head;
            @(posedge clock);
            model_commit();
            #1;
            n_cmp++;
            if (int'(free_count) !== (m_tail - m_head)) begin n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, free_count, m_tail - m_head); end
            n_cmp++;
            if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d: got %0b want %0b", cyc, overflow, m_ovf); end
            if (rec) begin
                for (int q = pool.size() - 1; q >= 0; q--) if (pool[q].pos >= live_cp) pool.delete(q);
                live = 1'b0;
            end else if (e_ok) begin
                r = 0;
                for (int i = 0; i < 4; i++) begin
                    if (areq[i]) begin
                        pool.push_back('{e_prf[i], old_head + r});
                        r++;
                    end
                end
            end
            if (chk && e_ok) begin
                live      = 1'b1;
                live_slot = int'(cidx);
                live_cp   = m_cp[cidx];
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc_all4();
        test_alloc_sparse();
        test_insufficient();
        test_checkpoint_recover();
        test_recover_with_free();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
